// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters.
// Sequences each frame: grant, start pulse, busy tracking with timeout, inter-frame gap.
module uart_tx_arbiter #(
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic [7:0] frame_cnt,
  output logic       err
);
  localparam int MAXC = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] GAP_LIM = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TO_LIM  = CW'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic [7:0]    r_frame, w_frame_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_err, w_err_nxt;
  logic          r_start, w_start_nxt;
  logic          r_rdy0, w_rdy0_nxt;
  logic          r_rdy1, w_rdy1_nxt;
  logic          w_winner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
      r_frame   <= 8'h00;
      r_grant   <= 1'b1;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_rdy0    <= 1'b0;
      r_rdy1    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_frame   <= w_frame_nxt;
      r_grant   <= w_grant_nxt;
      r_err     <= w_err_nxt;
      r_start   <= w_start_nxt;
      r_rdy0    <= w_rdy0_nxt;
      r_rdy1    <= w_rdy1_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tx_data_nxt = r_tx_data;
    w_frame_nxt   = r_frame;
    w_grant_nxt   = r_grant;
    w_err_nxt     = r_err;
    w_start_nxt   = 1'b0;
    w_rdy0_nxt    = 1'b0;
    w_rdy1_nxt    = 1'b0;
    w_winner      = 1'b0;
    w_cnt_inc     = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester that did not own the transmitter last wins.
          w_winner      = (req0_valid && req1_valid) ? ~r_grant : req1_valid;
          w_tx_data_nxt = w_winner ? req1_data : req0_data;
          w_grant_nxt   = w_winner;
          w_start_nxt   = 1'b1;
          w_rdy0_nxt    = ~w_winner;
          w_rdy1_nxt    = w_winner;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        // Counter tracks clocks elapsed since tx_start went high.
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (w_cnt_inc >= TO_LIM) begin
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_frame_nxt = r_frame + 8'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // A zero-length gap still spends one cycle here.
        if (w_cnt_inc >= GAP_LIM) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req0_ready = r_rdy0;
  assign req1_ready = r_rdy1;
  assign tx_start   = r_start;
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant;
  assign frame_cnt  = r_frame;
  assign err        = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration plus sequences
// for timeout, gap, counter wrap (zero-gap instance) and mid-frame reset.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_ready, req1_ready, tx_start, grant_id, err;
  logic [7:0] tx_data, frame_cnt;
  logic       tx_busy = 1'b0;

  logic       v0_a = 1'b0;
  logic [7:0] d0_a = 8'h5C;
  logic       rdy0_a, rdy1_a, start_a, gid_a, err_a;
  logic [7:0] txd_a, fc_a;
  logic       busy_a = 1'b0;

  int total = 0, bad = 0, cyc = 0;
  int n_start = 0, n_rdy1 = 0, n_start_a = 0;
  int fall_cyc = 0, n_fall = 0, m_cnt = 0, a_cnt = 0;
  bit model_en = 1'b1;
  bit b_new;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       exp_gid;
    logic [7:0] exp_data;
  } vec_t;
  vec_t vecs[8];

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .frame_cnt(frame_cnt), .err(err)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0), .BUSY_TIMEOUT(64)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0_a), .req0_data(d0_a), .req0_ready(rdy0_a),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(rdy1_a),
    .tx_start(start_a), .tx_data(txd_a), .tx_busy(busy_a),
    .grant_id(gid_a), .frame_cnt(fc_a), .err(err_a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Transmitter model: busy rises 2 clocks after start and stays high 20 clocks.
  always @(negedge clk) begin
    if (model_en && tx_start) m_cnt = 22;
    else if (m_cnt != 0) m_cnt--;
    b_new = (m_cnt != 0) && (m_cnt <= 20);
    if (tx_busy && !b_new) begin
      fall_cyc = cyc;
      n_fall++;
    end
    tx_busy = b_new;
  end

  // Short transmitter for the zero-gap instance: busy high 2 clocks.
  always @(negedge clk) begin
    if (start_a) a_cnt = 3;
    else if (a_cnt != 0) a_cnt--;
    busy_a = (a_cnt != 0) && (a_cnt < 3);
  end

  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) n_start++;
      if (req1_ready) n_rdy1++;
      if (start_a) n_start_a++;
      total++;
      if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && !tx_start) ||
          rdy1_a || (rdy0_a && !start_a)) begin
        bad++;
        $display("FAIL ready_rule: r0=%0b r1=%0b start=%0b a_r0=%0b a_r1=%0b a_start=%0b",
                 req0_ready, req1_ready, tx_start, rdy0_a, rdy1_a, start_a);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!tx_start && lat < 300);
    if (!tx_start) begin
      total++;
      bad++;
      $display("FAIL start_timeout: no tx_start after %0d clocks", lat);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start"}, tx_start, 0);
    chk({tag, "_rdy0"}, req0_ready, 0);
    chk({tag, "_rdy1"}, req1_ready, 0);
    chk({tag, "_data"}, tx_data, 8'h00);
    chk({tag, "_gid"}, grant_id, 1);
    chk({tag, "_fc"}, frame_cnt, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    int lat, t0, fc_before, s_before, r_before, f_before;
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[3] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 8'h22};
    vecs[4] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 8'h11};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 8'h77};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h78, 1'b1, 8'h78};
    vecs[7] = '{1'b1, 8'h5A, 1'b1, 8'hC3, 1'b0, 8'h5A};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;

    // 256 back-to-back frames on the zero-gap instance
    @(negedge clk);
    v0_a = 1'b1;
    for (int i = 0; i < 256; i++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!start_a && lat < 50);
      if (!start_a) begin
        total++;
        bad++;
        $display("FAIL wrap_start: frame %0d never started", i);
        break;
      end
      chk("wrap_fc", fc_a, i);
    end
    v0_a = 1'b0;
    repeat (10) @(negedge clk);
    chk("wrap_fc_end", fc_a, 0);
    chk("wrap_starts", n_start_a, 256);
    chk("wrap_data", txd_a, 8'h5C);
    chk("wrap_gid", gid_a, 0);
    chk("wrap_err", err_a, 0);

    // arbitration table; valids advance right after each accept
    for (int i = 0; i < 8; i++) begin
      req0_valid = vecs[i].v0;
      req0_data  = vecs[i].d0;
      req1_valid = vecs[i].v1;
      req1_data  = vecs[i].d1;
      wait_start(lat);
      if (i == 0) chk("first_latency", lat, 1);
      else chk("gap_ge16", (cyc - fall_cyc) >= 16, 1);
      chk("vec_data", tx_data, vecs[i].exp_data);
      chk("vec_gid", grant_id, vecs[i].exp_gid);
      chk("vec_rdy0", req0_ready, !vecs[i].exp_gid);
      chk("vec_rdy1", req1_ready, vecs[i].exp_gid);
      chk("vec_fc", frame_cnt, i);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (frame_cnt != 8'd8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("table_fc", frame_cnt, 8);

    // busy never rises: timeout
    repeat (20) @(negedge clk);
    model_en   = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 8'h3C;
    wait_start(lat);
    t0 = cyc;
    chk("to_data", tx_data, 8'h3C);
    chk("to_gid", grant_id, 1);
    chk("to_err_pre", err, 0);
    req1_valid = 1'b0;
    fc_before  = frame_cnt;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!err && lat < 200);
    chk("err_delay", cyc - t0, 64);
    model_en   = 1'b1;
    req0_valid = 1'b1;
    req0_data  = 8'hE7;
    f_before   = n_fall;
    wait_start(lat);
    chk("to_gap_latency", lat, 17);
    chk("to_fc_kept", frame_cnt, fc_before);
    chk("to_err_sticky", err, 1);
    req0_valid = 1'b0;

    // one-clock req1 pulse during the gap is dropped
    lat = 0;
    while (n_fall == f_before && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    s_before   = n_start;
    r_before   = n_rdy1;
    req1_valid = 1'b1;
    req1_data  = 8'h44;
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("gap_pulse_start", n_start, s_before);
    chk("gap_pulse_rdy1", n_rdy1, r_before);
    chk("gap_pulse_fc", frame_cnt, fc_before + 1);
    chk("err_still", err, 1);

    // reset while in WAIT_DONE, req0 held across reset
    req0_valid = 1'b1;
    req0_data  = 8'h5E;
    wait_start(lat);
    req0_valid = 1'b0;
    lat = 0;
    while (!tx_busy && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    repeat (3) @(negedge clk);
    req0_valid = 1'b1;
    req0_data  = 8'h96;
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    wait_start(lat);
    chk("post_rst_latency", lat, 1);
    chk("post_rst_data", tx_data, 8'h96);
    chk("post_rst_gid", grant_id, 0);
    chk("post_rst_rdy0", req0_ready, 1);
    chk("post_rst_fc0", frame_cnt, 0);
    req0_valid = 1'b0;
    lat = 0;
    while (frame_cnt == 8'd0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("post_rst_fc1", frame_cnt, 1);
    chk("post_rst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit engine between two byte requesters:
  - requester 0: switch-byte send on the S3 press.
  - requester 1: echo or loopback of received bytes.
- Sits between the requesters and the serial transmitter, which drives `dout`.
- Sequences each frame: arbitrate, start the transmitter, track busy, enforce an inter-frame gap.
- Detects a transmitter that never responds.

Parameters:
- GAP_CYCLES, 16: idle clocks enforced after each frame before the next grant; 0 means no gap.
- BUSY_TIMEOUT, 64: clocks allowed after `tx_start` for `tx_busy` to rise before the frame is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte; held high with data stable until accepted.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  one-cycle accept pulse to requester 0.
- req1_valid  in  1  requester 1 has a byte; same rules as requester 0.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  one-cycle accept pulse to requester 1.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte presented to the transmitter; stable from START until next grant.
- tx_busy  in  1  transmitter busy, high while a frame is shifting out.
- grant_id  out  1  requester that owns or last owned the transmitter.
- frame_cnt  out  8  count of completed frames.
- err  out  1  sticky; set when a BUSY_TIMEOUT expires.

Behaviour:
- Reset (`rst`=0, async) forces:
  - state IDLE; `req0_ready`=`req1_ready`=`tx_start`=0; `tx_data`=8'h00.
  - `grant_id`=1, so requester 0 wins the first tie.
  - `frame_cnt`=0; `err`=0; all counters 0.
- All outputs are registered.
- IDLE:
  - Only req0 valid: winner 0. Only req1 valid: winner 1.
  - Both valid: winner is the one not equal to `grant_id` (round-robin).
  - On the clock edge, latch `tx_data` from the winner's data and set `grant_id` to the winner, then go to START.
  - No valid: stay in IDLE.
- START (exactly one cycle):
  - `tx_start`=1 and the winner's `reqN_ready`=1 in the same cycle.
  - The transfer completes in that cycle. The requester must drop or advance `valid` at the next edge.
  - Clear the timeout counter, then go to WAIT_BUSY.
  - Latency from valid sampled in IDLE to `tx_start` is 1 clock.
- WAIT_BUSY:
  - `tx_busy`=1: go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches BUSY_TIMEOUT: set `err`=1, do not count the frame, go to GAP.
  - If `tx_busy` is already high in the first WAIT_BUSY cycle, it is accepted.
- WAIT_DONE:
  - Wait for `tx_busy`=0, with no timeout.
  - On the falling busy: increment `frame_cnt` (8-bit, wraps 255 to 0), go to GAP.
- GAP:
  - Count GAP_CYCLES clocks, then go to IDLE.
  - With GAP_CYCLES=0, GAP lasts one cycle.
  - Requests arriving during GAP wait; valid is simply held.
- Ready pulses:
  - Never asserted outside START.
  - Never asserted to both requesters.
  - A requester is never acknowledged without a matching `tx_start`.
- Ownership: valid deasserted by a requester before it is granted is dropped silently; no state is kept per requester.
- Reset mid-frame: state returns to IDLE immediately. The transmitter finishing its frame afterwards is ignored, because `tx_busy` is only observed in WAIT_BUSY/WAIT_DONE.
- Counter widths: sized for max(GAP_CYCLES, BUSY_TIMEOUT); no overflow possible.

Test Plan:
- Reset, then req0_valid=1 with data 8'hA5; transmitter model raises busy 2 clocks after start for 20 clocks. Expect:
  - `tx_start` and `req0_ready` high 1 clock after valid; `tx_data`=A5; `grant_id`=0.
  - `frame_cnt`=1 after busy falls; next grant no earlier than 16 clocks later.
- Both requesters valid continuously, data 8'h11 and 8'h22, over 4 frames. Expect grants 0,1,0,1, `tx_data` alternating 11/22, and no cycle with both readies high.
- `tx_busy` tied 0, req1 sends 8'h3C. Expect:
  - `err` rises exactly 64 clocks after `tx_start`, then returns to IDLE after the gap.
  - `frame_cnt` unchanged; `err` stays 1 until reset.
- GAP_CYCLES=0 and 256 back-to-back frames from req0. Expect `frame_cnt` to wrap to 0 and one `tx_start` per frame.
- Assert `rst`=0 during WAIT_DONE while busy=1. Expect all outputs at their reset values within the same cycle (async); after release, a new req0 request (held valid across reset) is granted normally.
- req1_valid pulses for 1 clock during GAP, then drops. Expect no grant, no ready, no `tx_start` for it.
